// File: rtl/fft_stream_tester.sv
// fft_stream_tester: plays an N-point complex frame from a stimulus RAM into a
// streaming FFT core, measures output latency and scores the output stream
// against a golden RAM with an absolute per-component tolerance.
// Build option: define FFT_TESTER_BITREV_EN to read the golden RAM in
// bit-reversed order for DUTs that emit bit-reversed output.
//
// state | meaning
// IDLE  | after reset; RAMs loadable; waits for start
// DRIVE | streams stimulus RAM to the DUT, one sample per cycle
// WAIT  | stimulus finished; counts latency until the first out_valid
// CHECK | compares each DUT output sample against the golden RAM
// DONE  | result held; RAMs loadable; waits for start
module fft_stream_tester #(
    parameter int N_POINTS = 256,
    parameter int DATA_W   = 16,
    parameter int TOL      = 0,
    parameter int TIMEOUT  = 1000,
    parameter int LAT_W    = 16,
    localparam int ADDR_W  = $clog2(N_POINTS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_en_i,
    input  logic              load_sel_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_real_i,
    input  logic [DATA_W-1:0] load_img_i,
    input  logic              start_i,
    output logic              in_valid_o,
    output logic [DATA_W-1:0] x_real_o,
    output logic [DATA_W-1:0] x_img_o,
    input  logic              out_valid_i,
    input  logic [DATA_W-1:0] y_real_i,
    input  logic [DATA_W-1:0] y_img_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [2:0]        err_code_o,
    output logic [ADDR_W-1:0] err_index_o,
    output logic [LAT_W-1:0]  latency_o
);

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

    localparam logic [2:0] ERR_OK = 3'd0, ERR_TIMEOUT = 3'd1, ERR_MISMATCH = 3'd2,
                           ERR_SHORT = 3'd3, ERR_LONG = 3'd4, ERR_EARLY = 3'd5;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);
    localparam logic [DATA_W:0]   TOL_V    = (DATA_W+1)'(TOL);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(TIMEOUT - 1);

    logic [DATA_W-1:0] stim_re [N_POINTS];
    logic [DATA_W-1:0] stim_im [N_POINTS];
    logic [DATA_W-1:0] gold_re [N_POINTS];
    logic [DATA_W-1:0] gold_im [N_POINTS];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              all_rcvd_q, all_rcvd_d;
    logic              in_valid_q, in_valid_d;
    logic [DATA_W-1:0] x_real_q, x_real_d, x_img_q, x_img_d;
    logic [2:0]        err_code_q, err_code_d;
    logic [ADDR_W-1:0] err_index_q, err_index_d;
    logic [LAT_W-1:0]  latency_q, latency_d;

    logic [ADDR_W-1:0] gold_addr;
    logic [DATA_W:0]   diff_re, diff_im, abs_re, abs_im;
    logic              sample_bad;
    logic              load_ok;

`ifdef FFT_TESTER_BITREV_EN
    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
        return r;
    endfunction
    assign gold_addr = bitrev(idx_q);
`else
    assign gold_addr = idx_q;
`endif

    // One extra bit keeps the difference of the two extreme values from wrapping.
    always_comb begin
        diff_re    = {y_real_i[DATA_W-1], y_real_i} - {gold_re[gold_addr][DATA_W-1], gold_re[gold_addr]};
        diff_im    = {y_img_i[DATA_W-1], y_img_i}   - {gold_im[gold_addr][DATA_W-1], gold_im[gold_addr]};
        abs_re     = diff_re[DATA_W] ? (~diff_re + 1'b1) : diff_re;
        abs_im     = diff_im[DATA_W] ? (~diff_im + 1'b1) : diff_im;
        sample_bad = (abs_re > TOL_V) || (abs_im > TOL_V);
    end

    assign load_ok = (state_q == S_IDLE) || (state_q == S_DONE);

    // RAM writes only while not running; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (load_en_i && load_ok) begin
            if (load_sel_i) begin
                gold_re[load_addr_i] <= load_real_i;
                gold_im[load_addr_i] <= load_img_i;
            end else begin
                stim_re[load_addr_i] <= load_real_i;
                stim_im[load_addr_i] <= load_img_i;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            all_rcvd_q  <= 1'b0;
            in_valid_q  <= 1'b0;
            x_real_q    <= '0;
            x_img_q     <= '0;
            err_code_q  <= ERR_OK;
            err_index_q <= '0;
            latency_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            all_rcvd_q  <= all_rcvd_d;
            in_valid_q  <= in_valid_d;
            x_real_q    <= x_real_d;
            x_img_q     <= x_img_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
            latency_q   <= latency_d;
        end
    end

    // Next-state logic: drive frame, time the DUT, then score its output.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        all_rcvd_d  = all_rcvd_q;
        in_valid_d  = in_valid_q;
        x_real_d    = x_real_q;
        x_img_d     = x_img_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        latency_d   = latency_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    // Sample 0 goes out on the entry edge, so idx points at sample 1.
                    state_d     = S_DRIVE;
                    idx_d       = ADDR_W'(1);
                    all_rcvd_d  = 1'b0;
                    in_valid_d  = 1'b1;
                    x_real_d    = stim_re[0];
                    x_img_d     = stim_im[0];
                    err_code_d  = ERR_OK;
                    err_index_d = '0;
                    latency_d   = '0;
                end
            end
            S_DRIVE: begin
                if (out_valid_i) begin
                    state_d     = S_DONE;
                    err_code_d  = ERR_EARLY;
                    err_index_d = '0;
                    in_valid_d  = 1'b0;
                    x_real_d    = '0;
                    x_img_d     = '0;
                end else if (idx_q == '0) begin
                    // idx wrapped: the last sample is on the bus this cycle.
                    state_d    = S_WAIT;
                    in_valid_d = 1'b0;
                    x_real_d   = '0;
                    x_img_d    = '0;
                end else begin
                    x_real_d = stim_re[idx_q];
                    x_img_d  = stim_im[idx_q];
                    idx_d    = idx_q + ADDR_W'(1);
                end
            end
            S_WAIT, S_CHECK: begin
                if (out_valid_i) begin
                    state_d = S_CHECK;
                    if (all_rcvd_q) begin
                        state_d     = S_DONE;
                        err_code_d  = ERR_LONG;
                        err_index_d = '0;
                    end else if (sample_bad) begin
                        state_d     = S_DONE;
                        err_code_d  = ERR_MISMATCH;
                        err_index_d = idx_q;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                        if (idx_q == LAST_IDX) all_rcvd_d = 1'b1;
                    end
                end else if (state_q == S_CHECK) begin
                    state_d = S_DONE;
                    if (!all_rcvd_q) begin
                        err_code_d  = ERR_SHORT;
                        err_index_d = idx_q;
                    end
                end else begin
                    latency_d = latency_q + LAT_W'(1);
                    if (latency_q == LAT_LAST) begin
                        state_d    = S_DONE;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_valid_o  = in_valid_q;
    assign x_real_o    = x_real_q;
    assign x_img_o     = x_img_q;
    assign busy_o      = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = done_o && (err_code_q == ERR_OK);
    assign err_code_o  = err_code_q;
    assign err_index_o = err_index_q;
    assign latency_o   = latency_q;

endmodule

// File: tb/tb_fft_stream_tester.sv
// Bench for fft_stream_tester: two instances (TOL=0 and TOL=1) share one
// behavioural frame-loopback DUT model; results are compared to a reference
// computed from the stimulus/golden arrays and the model configuration.
module tb_fft_stream_tester;
    localparam int N   = 256;
    localparam int W   = 16;
    localparam int AW  = 8;
    localparam int LW  = 16;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, load_en, load_sel, start;
    logic [AW-1:0] load_addr;
    logic [W-1:0]  load_re, load_im;
    logic          ov;
    logic [W-1:0]  yr, yi;

    logic          iv [2];
    logic [W-1:0]  xr [2];
    logic [W-1:0]  xi [2];
    logic          busy [2];
    logic          done [2];
    logic          pass [2];
    logic [2:0]    ecode [2];
    logic [AW-1:0] eidx [2];
    logic [LW-1:0] lat [2];

    fft_stream_tester #(.N_POINTS(N), .DATA_W(W), .TOL(0), .TIMEOUT(TMO), .LAT_W(LW)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .load_en_i(load_en), .load_sel_i(load_sel),
        .load_addr_i(load_addr), .load_real_i(load_re), .load_img_i(load_im), .start_i(start),
        .in_valid_o(iv[0]), .x_real_o(xr[0]), .x_img_o(xi[0]),
        .out_valid_i(ov), .y_real_i(yr), .y_img_i(yi),
        .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]),
        .err_code_o(ecode[0]), .err_index_o(eidx[0]), .latency_o(lat[0]));

    fft_stream_tester #(.N_POINTS(N), .DATA_W(W), .TOL(1), .TIMEOUT(TMO), .LAT_W(LW)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .load_en_i(load_en), .load_sel_i(load_sel),
        .load_addr_i(load_addr), .load_real_i(load_re), .load_img_i(load_im), .start_i(start),
        .in_valid_o(iv[1]), .x_real_o(xr[1]), .x_img_o(xi[1]),
        .out_valid_i(ov), .y_real_i(yr), .y_img_i(yi),
        .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]),
        .err_code_o(ecode[1]), .err_index_o(eidx[1]), .latency_o(lat[1]));

    logic signed [W-1:0] stim_re [N];
    logic signed [W-1:0] stim_im [N];
    logic signed [W-1:0] gold_re [N];
    logic signed [W-1:0] gold_im [N];

    int m_delay, m_count;
    bit m_never, m_early;

    int vectors = 0;
    int miscompares = 0;

    // Frame-loopback DUT model: captures the frame from instance 0, then replays
    // it m_delay cycles after in_valid falls, emitting m_count samples.
    int cap_n, x_bad, emitted, cnt, phase;
    logic [W-1:0] cap_re [$];
    logic [W-1:0] cap_im [$];
    initial begin
        ov = 1'b0; yr = '0; yi = '0;
        cap_n = 0; x_bad = 0; emitted = 0; cnt = 0; phase = 3;
        forever begin
            @(negedge clk);
            ov = 1'b0;
            yr = W'($urandom);
            yi = W'($urandom);
            if (start || !rst_n) begin
                phase = 0; cap_n = 0; x_bad = 0; emitted = 0;
                cap_re.delete(); cap_im.delete();
            end else begin
                if (phase == 0) begin
                    if (iv[0]) begin
                        if (cap_n < N && (xr[0] !== stim_re[cap_n] || xi[0] !== stim_im[cap_n])) x_bad++;
                        cap_re.push_back(xr[0]);
                        cap_im.push_back(xi[0]);
                        cap_n++;
                        if (m_early && cap_n == 10) ov = 1'b1;
                    end else if (cap_n > 0) begin
                        if (m_never || m_early) phase = 3;
                        else begin cnt = m_delay; phase = 1; end
                    end
                end
                if (phase == 1) begin
                    if (cnt == 0) phase = 2;
                    else cnt--;
                end
                if (phase == 2) begin
                    if (emitted < m_count) begin
                        ov = 1'b1;
                        yr = (emitted < cap_n) ? cap_re[emitted] : '0;
                        yi = (emitted < cap_n) ? cap_im[emitted] : '0;
                        emitted++;
                    end else phase = 3;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input bit sel, input int addr, input logic [W-1:0] re, input logic [W-1:0] im);
        load_en = 1'b1; load_sel = sel; load_addr = AW'(addr); load_re = re; load_im = im;
        tick();
        load_en = 1'b0;
    endtask

    task automatic load_all();
        for (int k = 0; k < N; k++) write_entry(1'b0, k, stim_re[k], stim_im[k]);
        for (int k = 0; k < N; k++) write_entry(1'b1, k, gold_re[k], gold_im[k]);
    endtask

    task automatic randomize_frame();
        for (int k = 0; k < N; k++) begin
            stim_re[k] = W'($urandom);
            stim_im[k] = W'($urandom);
            gold_re[k] = stim_re[k];
            gold_im[k] = stim_im[k];
        end
    endtask

    task automatic set_mode(input int d, input int c, input bit nev, input bit early);
        m_delay = d; m_count = c; m_never = nev; m_early = early;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Expected result from the frame contents and the model configuration.
    function automatic void ref_result(input int tol, output int code, output int idx, output int latency);
        int n_cmp;
        code = 0; idx = 0; latency = m_delay;
        if (m_early) begin code = 5; latency = 0; return; end
        if (m_never) begin code = 1; latency = TMO; return; end
        n_cmp = (m_count < N) ? m_count : N;
        for (int k = 0; k < n_cmp; k++) begin
            if (iabs(int'(stim_re[k]) - int'(gold_re[k])) > tol ||
                iabs(int'(stim_im[k]) - int'(gold_im[k])) > tol) begin
                code = 2; idx = k; return;
            end
        end
        if (m_count < N) begin code = 3; idx = m_count; end
        else if (m_count > N) code = 4;
    endfunction

    task automatic run(input bit busy_write);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (busy_write) write_entry(1'b1, 3, ~gold_re[3], ~gold_im[3]);
        n = 0;
        while (!(done[0] && done[1]) && n < 4000) begin
            tick();
            n++;
        end
        chk("run_completed", 32'(done[0] && done[1]), 32'd1);
    endtask

    task automatic check_run(input string tag, input bit chk_frame);
        int code, idx, latency;
        for (int u = 0; u < 2; u++) begin
            ref_result(u, code, idx, latency);
            chk($sformatf("%s_u%0d_err_code", tag, u), 32'(ecode[u]), 32'(code));
            chk($sformatf("%s_u%0d_err_index", tag, u), 32'(eidx[u]), 32'(idx));
            chk($sformatf("%s_u%0d_latency", tag, u), 32'(lat[u]), 32'(latency));
            chk($sformatf("%s_u%0d_pass", tag, u), 32'(pass[u]), 32'(code == 0));
            chk($sformatf("%s_u%0d_busy", tag, u), 32'(busy[u]), 32'd0);
        end
        if (chk_frame) begin
            chk({tag, "_in_valid_cycles"}, 32'(cap_n), 32'(N));
            chk({tag, "_x_samples_wrong"}, 32'(x_bad), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; load_en = 1'b0; load_sel = 1'b0; load_addr = '0;
        load_re = '0; load_im = '0; start = 1'b0;
        set_mode(5, N, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("reset_in_valid", 32'(iv[0]), 32'd0);
        chk("reset_x_real", 32'(xr[0]), 32'd0);
        chk("reset_busy", 32'(busy[0]), 32'd0);
        chk("reset_done", 32'(done[0]), 32'd0);
        chk("reset_pass", 32'(pass[0]), 32'd0);
        chk("reset_err_code", 32'(ecode[0]), 32'd0);
        chk("reset_latency", 32'(lat[0]), 32'd0);

        // Clean loopback, 5-cycle latency.
        randomize_frame(); load_all();
        set_mode(5, N, 1'b0, 1'b0);
        run(1'b0);
        check_run("loopback", 1'b1);
        chk("loopback_done", 32'(done[0]), 32'd1);

        // Golden off by one LSB at index 37.
        randomize_frame();
        stim_re[37] = W'($urandom_range(0, 1000));
        gold_re[37] = stim_re[37] + 16'sd1;
        load_all();
        run(1'b0);
        check_run("off_by_one_37", 1'b0);

        // Random latency; a golden write while busy must be ignored.
        randomize_frame(); load_all();
        set_mode($urandom_range(0, 20), N, 1'b0, 1'b0);
        run(1'b1);
        check_run("rand_latency_busy_write", 1'b1);

        // Extreme values: the difference must not wrap.
        randomize_frame();
        stim_re[0] = 16'sh7FFF;
        gold_re[0] = 16'sh8000;
        load_all();
        set_mode(5, N, 1'b0, 1'b0);
        run(1'b0);
        check_run("extremes", 1'b0);

        randomize_frame(); load_all();
        set_mode(5, N, 1'b1, 1'b0);
        run(1'b0);
        check_run("timeout", 1'b1);

        set_mode(3, N - 1, 1'b0, 1'b0);
        run(1'b0);
        check_run("short", 1'b1);

        set_mode(3, N + 1, 1'b0, 1'b0);
        run(1'b0);
        check_run("long", 1'b1);

        set_mode(3, N, 1'b0, 1'b1);
        run(1'b0);
        check_run("early", 1'b0);

        // Reset during DRIVE at sample 100, then a full rerun.
        set_mode(5, N, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        chk("pre_reset_in_valid", 32'(iv[0]), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("midrun_reset_in_valid", 32'(iv[0]), 32'd0);
        chk("midrun_reset_busy", 32'(busy[0]), 32'd0);
        chk("midrun_reset_done", 32'(done[0]), 32'd0);
        rst_n = 1'b1;
        tick();
        run(1'b0);
        check_run("after_reset", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_stream_tester.md
Name: fft_stream_tester

Overview:
- Synthesizable, parametrised stimulus player and scoreboard for streaming FFT cores.
- Plays an N-point complex frame from an internal stimulus RAM into the DUT, then measures output latency.
- Checks the DUT output stream against an internal golden RAM, with an absolute tolerance.
- Used both in on-FPGA self-test and in simulation benches in place of hand-written pattern code.

Parameters:
- N_POINTS, 256: frame length. Must be a power of two, minimum 4. ADDR_W = clog2(N_POINTS) is derived as a localparam.
- DATA_W, 16: signed two's-complement sample width, real and imag.
- TOL, 0: maximum allowed |dut - golden|, in LSBs, per component.
- TIMEOUT, 1000: maximum number of wait cycles before out_valid.
- LAT_W, 16: width of the latency counter. Must be able to hold TIMEOUT.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- load_en, in, 1: write strobe for a RAM entry.
- load_sel, in, 1: RAM select; 0 = stimulus RAM, 1 = golden RAM.
- load_addr, in, ADDR_W: RAM write address.
- load_real, in, DATA_W: real part of the written entry.
- load_img, in, DATA_W: imag part of the written entry.
- start, in, 1: begin a test run. Sampled in IDLE or DONE only.
- in_valid, out, 1: stimulus valid, driven to the DUT.
- x_real, out, DATA_W: stimulus real part, driven to the DUT.
- x_img, out, DATA_W: stimulus imag part, driven to the DUT.
- out_valid, in, 1: DUT output valid.
- y_real, in, DATA_W: DUT output real part.
- y_img, in, DATA_W: DUT output imag part.
- busy, out, 1: high in DRIVE, WAIT and CHECK.
- done, out, 1: high in DONE.
- pass, out, 1: done && err_code==0.
- err_code, out, 3: result code. 0 OK, 1 TIMEOUT, 2 MISMATCH, 3 SHORT, 4 LONG, 5 EARLY.
- err_index, out, ADDR_W: output sample index at which the first error occurred.
- latency, out, LAT_W: count of cycles from the first cycle after the last stimulus to the first out_valid.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. RAM contents are not cleared.
  - Reset asserted mid-run aborts the run: state goes to IDLE and in_valid drops on the next edge.
- Loads: load_en writes the selected RAM in IDLE or DONE only. Writes while busy are ignored.
- IDLE/DONE -> DRIVE on start.
  - On entry: clear the sample index, latency, err_code and err_index.
  - done and pass fall in the same edge.
- DRIVE:
  - Registered outputs: in_valid=1 and x = stim[idx] for exactly N_POINTS consecutive cycles. idx increments each cycle.
  - After the last sample: in_valid=0, x driven 0, state -> WAIT.
  - out_valid=1 at any time during DRIVE: err_code=EARLY, err_index=0, state -> DONE, in_valid=0.
- WAIT:
  - latency increments every cycle with out_valid=0.
  - When latency reaches TIMEOUT: err_code=TIMEOUT, state -> DONE.
  - First cycle with out_valid=1: state -> CHECK, and that sample is compared as index 0 in the same cycle. No samples are lost.
- CHECK (every cycle out_valid=1, index k):
  - Sign-extend both operands to DATA_W+1 bits, subtract, and take the absolute value.
  - Fail if either component's difference exceeds TOL.
  - On the first failure: err_code=MISMATCH, err_index=k, state -> DONE.
  - out_valid falls with count < N_POINTS: err_code=SHORT, err_index=count, state -> DONE.
  - out_valid still high on the cycle after sample N_POINTS-1: err_code=LONG, err_index=0, state -> DONE.
  - out_valid falls exactly after N_POINTS samples: err_code=OK, state -> DONE.
- DONE: done, pass, err_code, err_index and latency hold until the next start or reset.
- start while busy is ignored.
- Arithmetic boundary: the difference between the extremes -2^(DATA_W-1) and 2^(DATA_W-1)-1 must not overflow. This is why the extra bit is required.
- Index counters wrap modulo N_POINTS. Wrap is never observable because of the LONG check.

Optional Feature:
- Macro FFT_TESTER_BITREV_EN.
- Defined: the golden RAM read address in CHECK is the ADDR_W-bit bit-reversal of k. This supports DUTs that emit in bit-reversed order. err_index still reports the natural-order k.
- Undefined: golden address = k, natural order.

Test Plan:
- Loopback DUT model (y = x delayed 5 cycles), golden = stimulus, TOL=0 -> done=1, pass=1, err_code=0, latency=5, in_valid high exactly 256 cycles.
- Same setup with golden[37].real +1: TOL=0 gives err_code=2, err_index=37. TOL=1 gives pass=1.
- Stimulus 0x7FFF, golden 0x8000, TOL=0 -> MISMATCH at index 0, with no wrap to a small difference.
- DUT never asserts out_valid -> err_code=1 after exactly 1000 WAIT cycles, latency=1000.
- DUT emits 255 samples -> SHORT, err_index=255. DUT emits 257 samples -> LONG.
- rst_n low for 1 cycle at DRIVE sample 100 -> next edge: in_valid=0, busy=0, done=0. A subsequent start reruns the full 256 samples and passes.
